// File: rtl/thread_fetch_unit.sv
// Four-thread round-robin instruction fetch: per-thread PCs, one outstanding
// synchronous RAM read (F1) and the IF/ID register, with stall and branch squash.
module thread_pc #(
    parameter int                ADDR_W = 9,
    parameter logic [ADDR_W-1:0] RST_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] target,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);
    // A redirect wins over the issue increment in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    pc <= RST_PC;
        else if (load) pc <= target;
        else if (inc)  pc <= pc + 1'b1;
    end
endmodule

module thread_fetch_unit #(
    parameter int ADDR_W  = 9,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               stall,
    input  logic               br_valid,
    input  logic [1:0]         br_tid,
    input  logic [ADDR_W-1:0]  br_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               ifid_valid,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [3:0]         ifid_op,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic [1:0]         ifid_tid
);
    logic [3:0][ADDR_W-1:0] pc;
    logic [1:0]             cur_tid;
    logic                   f1_valid;
    logic [ADDR_W-1:0]      f1_pc;
    logic [1:0]             f1_tid;
    logic                   issue;
    logic                   squash;

    assign issue  = en && !stall;
    assign squash = br_valid && f1_valid && (f1_tid == br_tid);

    for (genvar t = 0; t < 4; t++) begin : g_thr
        thread_pc #(
            .ADDR_W (ADDR_W),
            .RST_PC (ADDR_W'(t) << (ADDR_W - 2))
        ) u_pc (
            .clk    (clk),
            .rst_n  (rst_n),
            .load   (br_valid && (br_tid == 2'(t))),
            .target (br_target),
            .inc    (issue && (cur_tid == 2'(t))),
            .pc     (pc[t])
        );
    end

    // While stalled the RAM re-reads the in-flight address so its data is
    // still on imem_rdata when IF/ID finally accepts it.
    always_comb begin
        imem_addr = pc[cur_tid];
        if (!rst_n)     imem_addr = '0;
        else if (stall) imem_addr = f1_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     cur_tid <= 2'd0;
        else if (issue) cur_tid <= cur_tid + 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f1_valid <= 1'b0;
            f1_pc    <= '0;
            f1_tid   <= 2'd0;
        end else if (!stall) begin
            f1_valid <= issue;
            if (issue) begin
                f1_pc  <= pc[cur_tid];
                f1_tid <= cur_tid;
            end
        end else if (squash) begin
            f1_valid <= 1'b0;
        end
    end

    // A squashed F1 entry may still advance this edge; it lands as a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
            ifid_pc    <= '0;
            ifid_tid   <= 2'd0;
        end else if (!stall) begin
            ifid_valid <= f1_valid && !squash;
            ifid_instr <= imem_rdata;
            ifid_pc    <= f1_pc;
            ifid_tid   <= f1_tid;
        end
    end

    assign ifid_op = ifid_instr[INSTR_W-1 -: 4];
endmodule

// File: tb/tb_thread_fetch_unit.sv
// Directed bench for thread_fetch_unit: RAM model returns a word derived from
// its address, expected fetch order and redirect effects are hand-computed.
module tb_thread_fetch_unit;
    localparam int AW = 9;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          stall = 1'b0;
    logic          br_valid = 1'b0;
    logic [1:0]    br_tid = 2'd0;
    logic [AW-1:0] br_target = '0;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata;
    logic          ifid_valid;
    logic [IW-1:0] ifid_instr;
    logic [3:0]    ifid_op;
    logic [AW-1:0] ifid_pc;
    logic [1:0]    ifid_tid;

    int n_chk = 0;
    int n_err = 0;
    int k;

    always #5 clk = ~clk;

    thread_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .stall      (stall),
        .br_valid   (br_valid),
        .br_tid     (br_tid),
        .br_target  (br_target),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .ifid_valid (ifid_valid),
        .ifid_instr (ifid_instr),
        .ifid_op    (ifid_op),
        .ifid_pc    (ifid_pc),
        .ifid_tid   (ifid_tid)
    );

    // Word holds its own address in the low bits and addr[3:0] as the OP field.
    function automatic logic [IW-1:0] word(input logic [AW-1:0] a);
        return {a[3:0], 19'd0, a};
    endfunction

    always_ff @(posedge clk) imem_rdata <= word(imem_addr);

    // Address of the i-th issue after reset with no redirects.
    function automatic logic [AW-1:0] addr_of(input int i);
        return AW'((i % 4) * (1 << (AW - 2)) + i / 4);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_if(input string tag, input logic v, input logic [1:0] t, input logic [AW-1:0] p);
        logic [IW-1:0] w;
        w = word(p);
        chk({tag, ".valid"}, 32'(ifid_valid), 32'(v));
        if (v) begin
            chk({tag, ".tid"},   32'(ifid_tid),   32'(t));
            chk({tag, ".pc"},    32'(ifid_pc),    32'(p));
            chk({tag, ".instr"}, ifid_instr,      w);
            chk({tag, ".op"},    32'(ifid_op),    32'(w[IW-1 -: 4]));
        end
    endtask

    task automatic cyc(input logic e, input logic s, input logic b, input logic [1:0] bt, input logic [AW-1:0] tg);
        @(negedge clk);
        en = e; stall = s; br_valid = b; br_tid = bt; br_target = tg;
        #1;
    endtask

    // One cycle of an undisturbed stream; k counts issues since reset.
    task automatic stream(input logic s);
        cyc(1'b1, s, 1'b0, 2'd0, '0);
        chk("stream.addr", 32'(imem_addr), 32'(s ? addr_of(k - 1) : addr_of(k)));
        if (k >= 2) chk_if("stream", 1'b1, 2'((k - 2) % 4), addr_of(k - 2));
        else        chk_if("stream", 1'b0, 2'd0, '0);
        if (!s) k++;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".addr"},  32'(imem_addr),  32'd0);
        chk({tag, ".valid"}, 32'(ifid_valid), 32'd0);
        chk({tag, ".instr"}, ifid_instr,      32'd0);
        chk({tag, ".op"},    32'(ifid_op),    32'd0);
        chk({tag, ".pc"},    32'(ifid_pc),    32'd0);
        chk({tag, ".tid"},   32'(ifid_tid),   32'd0);
    endtask

    task automatic release_reset;
        @(posedge clk);
        #2;
        stall = 1'b0; br_valid = 1'b0; en = 1'b1; rst_n = 1'b1;
        k = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state, with en and stall asserted to show imem_addr stays 0.
        en = 1'b1; stall = 1'b1;
        #12;
        chk_reset("rst0");
        release_reset();

        // Round-robin stream, 3-cycle stall, then resume.
        for (int i = 0; i < 8; i++) stream(1'b0);
        for (int i = 0; i < 3; i++) stream(1'b1);
        for (int i = 0; i < 6; i++) stream(1'b0);

        // Asynchronous reset mid-stream while stalled.
        @(negedge clk);
        stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("arst");
        release_reset();
        for (int i = 0; i < 3; i++) stream(1'b0);

        // Redirect thread 2 while its fetch (pc 256) sits in F1.
        cyc(1'b1, 1'b0, 1'b1, 2'd2, AW'(9'h050));
        chk("sq.c3.addr", 32'(imem_addr), 32'd384);
        chk_if("sq.c3", 1'b1, 2'd1, AW'(128));
        cyc(1'b1, 1'b0, 1'b0, 2'd0, '0);
        chk("sq.c4.addr", 32'(imem_addr), 32'd1);
        chk_if("sq.c4", 1'b0, 2'd0, '0);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, '0);
        chk("sq.c5.addr", 32'(imem_addr), 32'd129);
        chk_if("sq.c5", 1'b1, 2'd3, AW'(384));
        cyc(1'b1, 1'b0, 1'b0, 2'd0, '0);
        chk("sq.c6.addr", 32'(imem_addr), 32'h050);
        chk_if("sq.c6", 1'b1, 2'd0, AW'(1));
        cyc(1'b1, 1'b0, 1'b0, 2'd0, '0);
        chk("sq.c7.addr", 32'(imem_addr), 32'd385);
        chk_if("sq.c7", 1'b1, 2'd1, AW'(129));
        cyc(1'b1, 1'b0, 1'b0, 2'd0, '0);
        chk("sq.c8.addr", 32'(imem_addr), 32'd2);
        chk_if("sq.c8", 1'b1, 2'd2, AW'(9'h050));

        // Redirect the issuing thread (3) to 511, then wrap to 0; en gap.
        @(negedge clk);
        rst_n = 1'b0;
        release_reset();
        for (int c = 0; c < 3; c++) begin
            cyc(1'b1, 1'b0, 1'b0, 2'd0, '0);
            chk("rr.addr", 32'(imem_addr), 32'(addr_of(c)));
        end
        cyc(1'b1, 1'b0, 1'b1, 2'd3, AW'(511));
        chk("rr.c3.addr", 32'(imem_addr), 32'd384);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, '0);
        chk("rr.c4.addr", 32'(imem_addr), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, '0);
        chk("rr.c5.addr", 32'(imem_addr), 32'd129);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, '0);
        chk("rr.c6.addr", 32'(imem_addr), 32'd257);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, '0);
        chk("brcur.c7.addr", 32'(imem_addr), 32'd511);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, '0);
        chk("rr.c8.addr", 32'(imem_addr), 32'd2);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, '0);
        chk("rr.c9.addr", 32'(imem_addr), 32'd130);
        chk_if("brcur.c9", 1'b1, 2'd3, AW'(511));
        cyc(1'b1, 1'b0, 1'b0, 2'd0, '0);
        chk("rr.c10.addr", 32'(imem_addr), 32'd258);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, '0);
        chk("wrap.c11.addr", 32'(imem_addr), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 2'd0, '0);
        chk("en0.c12.addr", 32'(imem_addr), 32'd3);
        chk_if("en0.c12", 1'b1, 2'd2, AW'(258));
        cyc(1'b1, 1'b0, 1'b0, 2'd0, '0);
        chk("en0.c13.addr", 32'(imem_addr), 32'd3);
        chk_if("wrap.c13", 1'b1, 2'd3, AW'(0));
        cyc(1'b1, 1'b0, 1'b0, 2'd0, '0);
        chk("en0.c14.addr", 32'(imem_addr), 32'd131);
        chk_if("en0.c14", 1'b0, 2'd0, '0);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, '0);
        chk_if("en0.c15", 1'b1, 2'd0, AW'(3));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/thread_fetch_unit.md
THREAD_FETCH_UNIT -- requirements
Module: thread_fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, instruction-memory word-address width.
REQ-002 SHALL have parameter INSTR_W, default 32, instruction width; OP field = instr[INSTR_W-1:INSTR_W-4].
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port en  input  1  run enable; 1 = issue fetches.
REQ-006 SHALL have port stall  input  1  downstream hold of IF/ID and fetch pipeline.
REQ-007 SHALL have port br_valid  input  1  taken-branch redirect strobe, one cycle.
REQ-008 SHALL have port br_tid  input  2  thread being redirected.
REQ-009 SHALL have port br_target  input  ADDR_W  redirect word address.
REQ-010 SHALL have port imem_addr  output  ADDR_W  synchronous instruction-RAM read address; data returns next cycle.
REQ-011 SHALL have port imem_rdata  input  INSTR_W  instruction-RAM read data.
REQ-012 SHALL have port ifid_valid  output  1  IF/ID entry valid.
REQ-013 SHALL have port ifid_instr  output  INSTR_W  fetched instruction.
REQ-014 SHALL have port ifid_op  output  4  OP field of ifid_instr, driven combinationally to the control unit.
REQ-015 SHALL have port ifid_pc  output  ADDR_W  address of ifid_instr.
REQ-016 SHALL have port ifid_tid  output  2  thread of ifid_instr.

Function
REQ-017 SHALL hold four per-thread PCs pc[0..3] and a 2-bit round-robin pointer cur_tid.
REQ-018 SHALL hold F1 tracking registers f1_valid, f1_pc, f1_tid for the outstanding RAM read.
REQ-019 Issue condition: en=1 and stall=0; on issue imem_addr = pc[cur_tid], and at the edge f1 <= {1, pc[cur_tid], cur_tid}, pc[cur_tid] <= pc[cur_tid]+1 (mod 2^ADDR_W), cur_tid <= cur_tid+1 (3 wraps to 0).
REQ-020 When stall=0 and en=0: imem_addr = pc[cur_tid]; f1_valid <= 0; PCs and cur_tid hold.
REQ-021 When stall=1: imem_addr = f1_pc (re-read in-flight address); f1, cur_tid, PCs, all ifid_* hold, except REQ-023/024.
REQ-022 When stall=0: ifid_valid <= f1_valid, ifid_instr <= imem_rdata, ifid_pc <= f1_pc, ifid_tid <= f1_tid.
REQ-023 br_valid=1: pc[br_tid] <= br_target at the edge, overriding the increment of REQ-019 if cur_tid==br_tid that cycle; stall does not block the redirect.
REQ-024 br_valid=1 and f1_valid=1 and f1_tid==br_tid: the F1 entry SHALL be squashed (f1_valid <= 0, or ifid_valid <= 0 if it advances that edge); ifid_valid SHALL NOT be cleared for an entry already in IF/ID.
REQ-025 Latency: address issued in cycle N -> ifid_valid=1 with that instruction in cycle N+2 absent stall.
REQ-026 Stall of k cycles SHALL add exactly k cycles latency with no lost or duplicated instruction.
REQ-027 ifid_op SHALL equal ifid_instr[INSTR_W-1:INSTR_W-4] at all times.

Reset
REQ-028 rst_n=0 SHALL immediately set pc[t] = t << (ADDR_W-2) (0, 128, 256, 384 at default), cur_tid=0, f1_valid=0, ifid_valid=0, ifid_instr=0, ifid_pc=0, ifid_tid=0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight fetches; first issue after release SHALL be thread 0 at address 0.
REQ-030 imem_addr SHALL be 0 while rst_n=0.

Verification
REQ-031 Reset release, en=1, RAM holds word = address -> ifid sequence (tid,pc): (0,0),(1,128),(2,256),(3,384),(0,1)..., first valid 2 cycles after first issue.
REQ-032 Stall 3 cycles mid-stream -> ifid_* frozen, imem_addr = f1_pc, then sequence resumes with no gap or repeat.
REQ-033 br_valid, br_tid=2, br_target=0x050 while f1_tid=2 -> that fetch squashed; next thread-2 fetch at 0x050.
REQ-034 br_valid for thread equal to cur_tid on an issue cycle -> pc = br_target, not incremented value.
REQ-035 pc[3]=511 issued -> next thread-3 fetch at address 0 (wrap).
REQ-036 rst_n pulsed low mid-stream with stall=1 -> all outputs reset asynchronously; restart per REQ-031.
